// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array operand feeder: FSM state type and
// phase lengths expressed as functions of the array dimension.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } feeder_state_e;

  localparam int CLEAR_LEN = 1;

  function automatic int stream_len(input int dim);
    return 2 * dim - 1;
  endfunction

  function automatic int drain_len(input int dim);
    return dim;
  endfunction

  function automatic int step_width(input int dim);
    return $clog2(3 * dim);
  endfunction

endpackage

// File: rtl/operand_bank.sv
// DIM x DIM operand store with a single write port and a diagonal-skewed read:
// lane i presents element (i, t-i) row-major, or (t-i, i) when COL_MAJOR is set.
module operand_bank
  import systolic_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIM       = 10,
  parameter bit COL_MAJOR = 1'b0
) (
  input  logic                         clock,
  input  logic                         wr_en_i,
  input  logic [$clog2(DIM)-1:0]       wr_row_i,
  input  logic [$clog2(DIM)-1:0]       wr_col_i,
  input  logic [WIDTH-1:0]             wr_data_i,
  input  logic [step_width(DIM)-1:0]   step_i,
  output logic [WIDTH-1:0]             skew_o [DIM]
);

  localparam int IW = $clog2(DIM);

  logic [WIDTH-1:0] mem_q [DIM][DIM];

  // Storage has no reset: contents are only defined once written.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  int diff;

  always_comb begin
    diff = 0;
    for (int i = 0; i < DIM; i++) begin
      skew_o[i] = '0;
      diff = int'(step_i) - i;
      if (diff >= 0 && diff < DIM) begin
        if (COL_MAJOR) begin
          skew_o[i] = mem_q[diff[IW-1:0]][IW'(i)];
        end else begin
          skew_o[i] = mem_q[IW'(i)][diff[IW-1:0]];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A/B operand matrices, then streams them diagonally skewed into a
// DIM x DIM systolic array: clear, stream 2*DIM-1 steps, drain DIM, done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIM   = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [$clog2(DIM)-1:0] wr_row,
  input  logic [$clog2(DIM)-1:0] wr_col,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   array_clear,
  output logic [WIDTH-1:0]       out_left [DIM],
  output logic [WIDTH-1:0]       out_top  [DIM]
);

  localparam int CW         = step_width(DIM);
  localparam int STREAM_LEN = stream_len(DIM);
  localparam int DRAIN_LEN  = drain_len(DIM);

  feeder_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             clear_q, clear_d;
  logic [WIDTH-1:0] left_q [DIM];
  logic [WIDTH-1:0] left_d [DIM];
  logic [WIDTH-1:0] top_q  [DIM];
  logic [WIDTH-1:0] top_d  [DIM];
  logic [WIDTH-1:0] left_skew [DIM];
  logic [WIDTH-1:0] top_skew  [DIM];

  logic in_range, wr_ok;

  // Writes land only while idle; reset suppresses a coincident write.
  assign in_range = (int'(wr_row) < DIM) && (int'(wr_col) < DIM);
  assign wr_ok    = wr_en && !reset && (state_q == IDLE) && in_range;

  operand_bank #(
    .WIDTH     (WIDTH),
    .DIM       (DIM),
    .COL_MAJOR (1'b0)
  ) u_bank_a (
    .clock     (clock),
    .wr_en_i   (wr_ok && !wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (cnt_d),
    .skew_o    (left_skew)
  );

  operand_bank #(
    .WIDTH     (WIDTH),
    .DIM       (DIM),
    .COL_MAJOR (1'b1)
  ) u_bank_b (
    .clock     (clock),
    .wr_en_i   (wr_ok && wr_sel),
    .wr_row_i  (wr_row),
    .wr_col_i  (wr_col),
    .wr_data_i (wr_data),
    .step_i    (cnt_d),
    .skew_o    (top_skew)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        if (cnt_q == CW'(STREAM_LEN - 1)) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so the registers present step t
  // during the cycle the FSM spends on step t.
  always_comb begin
    clear_d = (state_d == CLEAR);
    done_d  = (state_d == DONE);
    for (int i = 0; i < DIM; i++) begin
      left_d[i] = (state_d == STREAM) ? left_skew[i] : '0;
      top_d[i]  = (state_d == STREAM) ? top_skew[i]  : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        left_q[i] <= '0;
        top_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      clear_q <= clear_d;
      for (int i = 0; i < DIM; i++) begin
        left_q[i] <= left_d[i];
        top_q[i]  <= top_d[i];
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign array_clear = clear_q;
  assign out_left    = left_q;
  assign out_top     = top_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Randomized bench for systolic_feeder: per-cycle stream check against the
// skew rule, plus a behavioural systolic multiply of the captured streams.
module tb_systolic_feeder;

  // DIM=5 gives 3-bit indices, so rows/cols 5..7 exercise the out-of-range guard.
  localparam int WIDTH       = 8;
  localparam int DIM         = 5;
  localparam int IW          = $clog2(DIM);
  localparam int PASS_CYCLES = 3 * DIM + 1;
  localparam int WINDOW      = 3 * DIM - 1;

  logic             clock;
  logic             reset;
  logic             wrEn;
  logic             wrSel;
  logic [IW-1:0]    wrRow;
  logic [IW-1:0]    wrCol;
  logic [WIDTH-1:0] wrData;
  logic             start;
  logic             busy;
  logic             done;
  logic             arrayClear;
  logic [WIDTH-1:0] outLeft [DIM];
  logic [WIDTH-1:0] outTop  [DIM];

  int vectors;
  int miscompares;
  int refA [DIM][DIM];
  int refB [DIM][DIM];
  int capL [WINDOW][DIM];
  int capT [WINDOW][DIM];

  systolic_feeder #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wrEn),
    .wr_sel      (wrSel),
    .wr_row      (wrRow),
    .wr_col      (wrCol),
    .wr_data     (wrData),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .array_clear (arrayClear),
    .out_left    (outLeft),
    .out_top     (outTop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    if (observed != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One idle-time write; the model follows the rule that out-of-range writes are dropped.
  task automatic applyStimulus(input bit sel, input int row, input int col, input int data);
    wrEn   = 1'b1;
    wrSel  = sel;
    wrRow  = IW'(row);
    wrCol  = IW'(col);
    wrData = WIDTH'(data);
    if (row < DIM && col < DIM) begin
      if (sel) refB[row][col] = data;
      else     refA[row][col] = data;
    end
    @(negedge clock);
    wrEn = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " done"}, int'(done), 0);
    checkOutput({tag, " clear"}, int'(arrayClear), 0);
    for (int i = 0; i < DIM; i++) begin
      checkOutput($sformatf("%s left[%0d]", tag, i), int'(outLeft[i]), 0);
      checkOutput($sformatf("%s top[%0d]", tag, i), int'(outTop[i]), 0);
    end
  endtask

  task automatic waitIdle();
    int budget;
    budget = 0;
    while (busy && budget < 100) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("idleWait busy", int'(busy), 0);
  endtask

  // Pulses start (with any write the caller already set up) and checks every
  // cycle of the pass; optionally re-pulses start or writes while busy.
  task automatic runPass(input int restartAt, input int busyWriteAt);
    int busyCycles, doneCount, t, d, expL, expT, acc, expP, l, r;
    busyCycles = 0;
    doneCount  = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wrEn  = 1'b0;
    for (int c = 0; c <= PASS_CYCLES; c++) begin
      t = c - 1;
      checkOutput($sformatf("busy c=%0d", c), int'(busy), (c < PASS_CYCLES) ? 1 : 0);
      checkOutput($sformatf("clear c=%0d", c), int'(arrayClear), (c == 0) ? 1 : 0);
      checkOutput($sformatf("done c=%0d", c), int'(done), (c == PASS_CYCLES - 1) ? 1 : 0);
      for (int i = 0; i < DIM; i++) begin
        expL = 0;
        expT = 0;
        d = t - i;
        if (c >= 1 && c <= 2 * DIM - 1 && d >= 0 && d < DIM) begin
          expL = refA[i][d];
          expT = refB[d][i];
        end
        checkOutput($sformatf("left[%0d] c=%0d", i, c), int'(outLeft[i]), expL);
        checkOutput($sformatf("top[%0d] c=%0d", i, c), int'(outTop[i]), expT);
        if (c >= 1 && c <= WINDOW) begin
          capL[c-1][i] = int'(outLeft[i]);
          capT[c-1][i] = int'(outTop[i]);
        end
      end
      busyCycles += int'(busy);
      doneCount  += int'(done);
      if (c == restartAt) start = 1'b1;
      if (c == busyWriteAt) begin
        wrEn   = 1'b1;
        wrSel  = 1'b0;
        wrRow  = '0;
        wrCol  = '0;
        wrData = WIDTH'(refA[0][0] + 1);
      end
      @(negedge clock);
      start = 1'b0;
      wrEn  = 1'b0;
    end
    checkOutput("busyCycles", busyCycles, PASS_CYCLES);
    checkOutput("donePulses", doneCount, 1);
    // Cell (i,j) sees left lane i delayed j steps and top lane j delayed i steps.
    for (int i = 0; i < DIM; i++) begin
      for (int j = 0; j < DIM; j++) begin
        acc  = 0;
        expP = 0;
        for (int s = 0; s < WINDOW; s++) begin
          l = (s - j >= 0) ? capL[s-j][i] : 0;
          r = (s - i >= 0) ? capT[s-i][j] : 0;
          acc += l * r;
        end
        for (int k = 0; k < DIM; k++) expP += refA[i][k] * refB[k][j];
        checkOutput($sformatf("result[%0d][%0d]", i, j), acc, expP);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset  = 1'b1;
    wrEn   = 1'b0;
    wrSel  = 1'b0;
    wrRow  = '0;
    wrCol  = '0;
    wrData = '0;
    start  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkIdle("reset");
    reset = 1'b0;
    @(negedge clock);
    checkIdle("postReset");

    $display("[TB] identity A times counting B");
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        applyStimulus(1'b0, r, c, (r == c) ? 1 : 0);
        applyStimulus(1'b1, r, c, DIM * r + c + 1);
      end
    end
    runPass(-1, -1);

    $display("[TB] constant operands with start re-pulsed mid-pass");
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        applyStimulus(1'b0, r, c, 2);
        applyStimulus(1'b1, r, c, 3);
      end
    end
    runPass(5, -1);

    $display("[TB] random operands, write while busy, out-of-range writes");
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        applyStimulus(1'b0, r, c, int'($urandom_range(255, 0)));
        applyStimulus(1'b1, r, c, int'($urandom_range(255, 0)));
      end
    end
    runPass(-1, 6);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(n[0], int'($urandom_range(7, DIM)), int'($urandom_range(DIM - 1, 0)), 8'hEE);
      applyStimulus(n[0], int'($urandom_range(DIM - 1, 0)), int'($urandom_range(7, DIM)), 8'hDD);
    end
    runPass(PASS_CYCLES - 1, -1);

    $display("[TB] write and start on the same edge");
    wrEn   = 1'b1;
    wrSel  = 1'b0;
    wrRow  = '0;
    wrCol  = '0;
    wrData = 8'd7;
    refA[0][0] = 7;
    runPass(-1, -1);

    $display("[TB] reset in the middle of streaming");
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("midPass left[0] t=2", int'(outLeft[0]), refA[0][2]);
    reset  = 1'b1;
    start  = 1'b1;
    wrEn   = 1'b1;
    wrSel  = 1'b0;
    wrRow  = IW'(1);
    wrCol  = IW'(1);
    wrData = WIDTH'(refA[1][1] + 1);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    wrEn  = 1'b0;
    checkIdle("midReset");
    @(negedge clock);
    checkIdle("afterReset");
    runPass(-1, -1);

    $display("[TB] random update rounds");
    for (int k = 0; k < 3; k++) begin
      waitIdle();
      for (int n = 0; n < 6; n++) begin
        applyStimulus(1'($urandom_range(1, 0)), int'($urandom_range(DIM - 1, 0)),
                      int'($urandom_range(DIM - 1, 0)), int'($urandom_range(255, 0)));
      end
      runPass(int'($urandom_range(PASS_CYCLES - 1, 0)), int'($urandom_range(PASS_CYCLES - 2, 0)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter WIDTH, default 8: operand element width in bits.
REQ-002 Parameter DIM, default 10: square matrix dimension; equals the DIM of the downstream systolic_array.
REQ-003 There SHALL be one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  operand write strobe.
REQ-007 wr_sel  input  1  0 = write matrix A (left operand), 1 = write matrix B (top operand).
REQ-008 wr_row  input  $clog2(DIM)  element row index.
REQ-009 wr_col  input  $clog2(DIM)  element column index.
REQ-010 wr_data  input  WIDTH  element value.
REQ-011 start  input  1  begin one multiply pass.
REQ-012 busy  output  1  high while a pass is in progress.
REQ-013 done  output  1  one-cycle pulse at pass end.
REQ-014 array_clear  output  1  drives the systolic_array reset to zero its accumulators.
REQ-015 out_left  output  WIDTH x [DIM]  skewed A stream; connects to systolic_array inp_left.
REQ-016 out_top  output  WIDTH x [DIM]  skewed B stream; connects to systolic_array inp_top.

Function
REQ-017 The states SHALL be IDLE, CLEAR, STREAM, DRAIN and DONE; busy = (state != IDLE).
REQ-018 IDLE: a write with wr_en=1 SHALL store wr_data into A[wr_row][wr_col] (wr_sel=0) or B[wr_row][wr_col] (wr_sel=1) at the clock edge.
REQ-019 Writes with wr_row or wr_col >= DIM SHALL be ignored; writes while busy=1 SHALL be ignored.
REQ-020 From IDLE, start=1 SHALL move to CLEAR; if wr_en and start are both high on the same edge, the write SHALL complete and the pass SHALL use the new value.
REQ-021 CLEAR lasts 1 cycle: array_clear=1 and all out_* = 0.
REQ-022 STREAM lasts 2*DIM-1 cycles, indexed t = 0..2*DIM-2; counter width is $clog2(3*DIM).
REQ-023 During STREAM cycle t, out_left[i] SHALL be A[i][t-i] when 0 <= t-i < DIM, else 0.
REQ-024 During STREAM cycle t, out_top[j] SHALL be B[t-j][j] when 0 <= t-j < DIM, else 0.
REQ-025 DRAIN lasts DIM cycles with all out_* = 0, so the last operands propagate to cell (DIM-1, DIM-1).
REQ-026 DONE lasts 1 cycle with done=1, then the state SHALL return to IDLE.
REQ-027 A complete pass from CLEAR through DONE SHALL keep busy high for exactly 3*DIM+1 cycles (31 cycles for DIM=10).
REQ-028 start while busy SHALL be ignored; it is not queued.
REQ-029 out_left, out_top, array_clear and done SHALL be registered outputs, with no combinational path from any input.
REQ-030 Operand storage SHALL keep its contents across passes; a second start without new writes SHALL repeat an identical stream.

Reset
REQ-031 reset=1 SHALL force state to IDLE, busy=0, done=0, array_clear=0, all out_* = 0, and counter = 0 on the next edge, including mid-pass.
REQ-032 Operand storage SHALL NOT be reset; its contents after power-up are undefined until written.
REQ-033 reset SHALL take priority over start and wr_en on the same edge.

Structure
REQ-034 A shared package systolic_pkg SHALL hold the state enum typedef and the cycle-count constants (CLEAR_LEN=1, STREAM_LEN=2*DIM-1, DRAIN_LEN=DIM) as functions or localparams of DIM.
REQ-035 One sub-module, operand_bank, SHALL be instantiated twice (A and B): it holds DIM x DIM storage plus a write port, and produces the diagonal-skewed DIM-wide read for step t with a parameter selecting row-major (A) or column-major (B) indexing.
REQ-036 The FSM and step counter SHALL reside in systolic_feeder.

Verification
REQ-037 DIM=4; A = identity, B[r][c] = 4r+c+1; start, then run systolic_array -> after done, result[r][c] = 4r+c+1.
REQ-038 DIM=4; all A = 2, all B = 3 -> at STREAM t=0 only out_left[0] and out_top[0] are nonzero (value 2 / 3); at t=6 only index 3 is nonzero; after done, every result = 24.
REQ-039 Pulse start, then pulse start again at cycle 5 -> exactly one pass; busy high for 13 cycles (DIM=4); exactly one done pulse.
REQ-040 Assert reset at STREAM t=2 -> next cycle busy=0 and all out_* = 0; a new start gives a full, correct pass.
REQ-041 Write with wr_row=4 (DIM=4), and a write while busy -> storage unchanged and the stream is identical to the previous pass.
REQ-042 Same-edge wr_en (A[0][0]=7) and start -> out_left[0] = 7 at STREAM t=0.
